// File: rtl/spi_master_query_pkg.sv
// Shared definitions for the SPI mode-0 query master: FSM state encoding,
// default timing constants and a counter-width helper.
package spi_master_query_pkg;

  // Top-level transaction states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } stateT;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_CLK_DIV   = 25;  // 1 MHz SCK from 50 MHz
  localparam int DEF_MAX_BYTES = 16;
  localparam int DEF_CNT_WIDTH = 5;
  localparam int DEF_SS_SETUP  = 4;
  localparam int DEF_BYTE_GAP  = 50;
  localparam logic [7:0] DEF_TX_FILL = 8'h00;

  // Bits needed to hold the values 0..maxVal (at least one bit)
  function automatic int widthFor(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/spi_master_byte_engine.sv
// Byte shifter for the SPI mode-0 master: SCK divider, TX/RX shift registers.
// One 'start' pulse clocks out a full frame; 'byteDone' is high during the
// last cycle of the frame (the cycle whose closing edge is the final SCK fall).
module spi_master_byte_engine
  import spi_master_query_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH,
  parameter int CLK_DIV       = DEF_CLK_DIV
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     load,
  input  logic [DATAWIDTH_BUS-1:0] txByte,
  input  logic                     start,
  input  logic                     miso,
  output logic                     sck,
  output logic                     mosi,
  output logic                     byteDone,
  output logic [DATAWIDTH_BUS-1:0] rxByte
);

  localparam int DIV_W = widthFor(CLK_DIV - 1);
  localparam int BIT_W = widthFor(DATAWIDTH_BUS - 1);

  logic                     activeReg;
  logic                     sckReg;
  logic [DIV_W-1:0]         divCntReg;
  logic [BIT_W-1:0]         bitCntReg;
  logic [DATAWIDTH_BUS-1:0] txShiftReg;
  logic [DATAWIDTH_BUS-1:0] rxShiftReg;
  logic                     edgeDue;
  logic                     fallDue;

  // An SCK edge happens when the half-period divider expires
  assign edgeDue  = activeReg && (divCntReg == DIV_W'(CLK_DIV - 1));
  assign fallDue  = edgeDue && sckReg;
  assign byteDone = fallDue && (bitCntReg == BIT_W'(DATAWIDTH_BUS - 1));

  assign sck    = sckReg;
  assign mosi   = txShiftReg[DATAWIDTH_BUS-1];
  assign rxByte = rxShiftReg;

  // Divider, SCK toggle, MISO capture on rise, MOSI shift on fall
  always_ff @(posedge clk) begin
    if (srst) begin
      activeReg  <= 1'b0;
      sckReg     <= 1'b0;
      divCntReg  <= '0;
      bitCntReg  <= '0;
      txShiftReg <= '0;
      rxShiftReg <= '0;
    end else begin
      if (start) begin
        activeReg <= 1'b1;
        sckReg    <= 1'b0;
        divCntReg <= '0;
        bitCntReg <= '0;
      end else if (activeReg) begin
        if (edgeDue) begin
          divCntReg <= '0;
          sckReg    <= ~sckReg;
          if (!sckReg) begin
            rxShiftReg <= {rxShiftReg[DATAWIDTH_BUS-2:0], miso};
          end else begin
            bitCntReg <= bitCntReg + BIT_W'(1);  // wraps to 0 after the last bit
            if (byteDone) begin
              activeReg <= 1'b0;
            end
          end
        end else begin
          divCntReg <= divCntReg + DIV_W'(1);
        end
      end

      // A load (next byte) wins over the final shift of the current byte
      if (load) begin
        txShiftReg <= txByte;
      end else if (fallDue) begin
        txShiftReg <= {txShiftReg[DATAWIDTH_BUS-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_master_query.sv
// SPI mode-0 query master: sends a command byte, then clocks N fill bytes
// and hands each received response byte to the local requester.
// Optional abort support is built when SPI_MASTER_QUERY_ABORT_EN is defined.
module spi_master_query
  import spi_master_query_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH,
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int MAX_BYTES     = DEF_MAX_BYTES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int SS_SETUP      = DEF_SS_SETUP,
  parameter int BYTE_GAP      = DEF_BYTE_GAP,
  parameter logic [DATAWIDTH_BUS-1:0] TX_FILL = DATAWIDTH_BUS'(DEF_TX_FILL)
) (
  input  logic                     SPI_MASTER_QUERY_CLOCK_50,
  input  logic                     SPI_MASTER_QUERY_RESET_InHigh,
  input  logic                     SPI_MASTER_QUERY_START_In,
  input  logic [DATAWIDTH_BUS-1:0] SPI_MASTER_QUERY_CMD_InBus,
  input  logic [CNT_WIDTH-1:0]     SPI_MASTER_QUERY_NBYTES_InBus,
  input  logic                     SPI_MASTER_QUERY_MISO_In,
`ifdef SPI_MASTER_QUERY_ABORT_EN
  input  logic                     SPI_MASTER_QUERY_ABORT_In,
  output logic                     SPI_MASTER_QUERY_ABORTED_Out,
`endif
  output logic                     SPI_MASTER_QUERY_SCK_Out,
  output logic                     SPI_MASTER_QUERY_MOSI_Out,
  output logic                     SPI_MASTER_QUERY_SS_OutLow,
  output logic [DATAWIDTH_BUS-1:0] SPI_MASTER_QUERY_RXDATA_OutBus,
  output logic                     SPI_MASTER_QUERY_RXVALID_Out,
  output logic                     SPI_MASTER_QUERY_BUSY_Out,
  output logic                     SPI_MASTER_QUERY_DONE_Out
);

  localparam int CYC_MAX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int CYC_W   = widthFor(CYC_MAX);

  logic clk;
  logic srst;
  assign clk  = SPI_MASTER_QUERY_CLOCK_50;
  assign srst = SPI_MASTER_QUERY_RESET_InHigh;

  stateT                    stateReg, stateNext;
  logic [CYC_W-1:0]         cycCntReg, cycCntNext;
  logic [CNT_WIDTH-1:0]     nBytesReg;
  logic [CNT_WIDTH-1:0]     byteIdxReg;   // index of the byte on the wire; 0 = command
  logic [CNT_WIDTH-1:0]     nBytesClamped;
  logic [DATAWIDTH_BUS-1:0] rxDataReg;
  logic                     rxValidReg;
  logic                     ssReg;
  logic                     busyReg;
  logic                     doneReg;
  logic                     startAccept;
  logic                     abortTake;

  logic                     engLoad;
  logic                     engStart;
  logic [DATAWIDTH_BUS-1:0] engTxByte;
  logic                     engSck;
  logic                     engMosi;
  logic                     byteDone;
  logic [DATAWIDTH_BUS-1:0] engRxByte;

  assign startAccept   = (stateReg == IDLE) && SPI_MASTER_QUERY_START_In;
  assign nBytesClamped = (SPI_MASTER_QUERY_NBYTES_InBus > CNT_WIDTH'(MAX_BYTES)) ?
                         CNT_WIDTH'(MAX_BYTES) : SPI_MASTER_QUERY_NBYTES_InBus;

  spi_master_byte_engine #(
    .DATAWIDTH_BUS (DATAWIDTH_BUS),
    .CLK_DIV       (CLK_DIV)
  ) uEngine (
    .clk      (clk),
    .srst     (srst),
    .load     (engLoad),
    .txByte   (engTxByte),
    .start    (engStart),
    .miso     (SPI_MASTER_QUERY_MISO_In),
    .sck      (engSck),
    .mosi     (engMosi),
    .byteDone (byteDone),
    .rxByte   (engRxByte)
  );

  // Next-state logic, engine handshakes and phase-counter update
  always_comb begin
    stateNext = stateReg;
    engLoad   = 1'b0;
    engStart  = 1'b0;
    engTxByte = SPI_MASTER_QUERY_CMD_InBus;
    case (stateReg)
      IDLE: begin
        if (SPI_MASTER_QUERY_START_In) begin
          stateNext = SETUP;
          engLoad   = 1'b1;
        end
      end
      SETUP: begin
        if (abortTake) begin
          stateNext = HOLD;
        end else if (cycCntReg == CYC_W'(SS_SETUP - 1)) begin
          stateNext = SHIFT;
          engStart  = 1'b1;
        end
      end
      SHIFT: begin
        if (byteDone) begin
          if (abortTake || (byteIdxReg == nBytesReg)) begin
            stateNext = HOLD;
          end else begin
            stateNext = GAP;
            engLoad   = 1'b1;
            engTxByte = TX_FILL;
          end
        end
      end
      GAP: begin
        if (abortTake) begin
          stateNext = HOLD;
        end else if (cycCntReg == CYC_W'(BYTE_GAP - 1)) begin
          stateNext = SHIFT;
          engStart  = 1'b1;
        end
      end
      HOLD: begin
        if (cycCntReg == CYC_W'(SS_SETUP - 1)) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Phase counter restarts on every state change and is unused in SHIFT
    if ((stateNext != stateReg) || (stateReg == SHIFT)) begin
      cycCntNext = '0;
    end else begin
      cycCntNext = cycCntReg + CYC_W'(1);
    end
  end

  // State register, byte bookkeeping and registered link/handshake outputs
  always_ff @(posedge clk) begin
    if (srst) begin
      stateReg   <= IDLE;
      cycCntReg  <= '0;
      nBytesReg  <= '0;
      byteIdxReg <= '0;
      rxDataReg  <= '0;
      rxValidReg <= 1'b0;
      ssReg      <= 1'b1;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      cycCntReg  <= cycCntNext;
      rxValidReg <= 1'b0;
      if (startAccept) begin
        nBytesReg  <= nBytesClamped;
        byteIdxReg <= '0;
      end
      if ((stateReg == SHIFT) && byteDone) begin
        // The byte clocked during the command carries nothing useful
        if (byteIdxReg != '0) begin
          rxDataReg  <= engRxByte;
          rxValidReg <= 1'b1;
        end
        if (stateNext == GAP) begin
          byteIdxReg <= byteIdxReg + CNT_WIDTH'(1);
        end
      end
      ssReg   <= (stateNext == IDLE) || (stateNext == DONE);
      busyReg <= (stateNext != IDLE);
      doneReg <= (stateNext == DONE);
    end
  end

`ifdef SPI_MASTER_QUERY_ABORT_EN
  logic abortPendReg;
  logic abortedFlagReg;
  logic abortedReg;

  // Abort acts immediately between bytes; during a byte it waits for the boundary
  always_comb begin
    abortTake = 1'b0;
    if ((stateReg == SETUP) || (stateReg == GAP)) begin
      abortTake = SPI_MASTER_QUERY_ABORT_In;
    end else if ((stateReg == SHIFT) && byteDone) begin
      abortTake = SPI_MASTER_QUERY_ABORT_In || abortPendReg;
    end
  end

  // Latch abort requests seen mid-byte and remember an honoured abort until DONE
  always_ff @(posedge clk) begin
    if (srst) begin
      abortPendReg   <= 1'b0;
      abortedFlagReg <= 1'b0;
      abortedReg     <= 1'b0;
    end else begin
      if ((stateReg == SHIFT) && !byteDone) begin
        abortPendReg <= abortPendReg || SPI_MASTER_QUERY_ABORT_In;
      end else begin
        abortPendReg <= 1'b0;
      end
      if (stateReg == IDLE) begin
        abortedFlagReg <= 1'b0;
      end else if (abortTake) begin
        abortedFlagReg <= 1'b1;
      end
      abortedReg <= (stateNext == DONE) && abortedFlagReg;
    end
  end

  assign SPI_MASTER_QUERY_ABORTED_Out = abortedReg;
`else
  assign abortTake = 1'b0;
`endif

  assign SPI_MASTER_QUERY_SCK_Out       = engSck;
  assign SPI_MASTER_QUERY_MOSI_Out      = engMosi;
  assign SPI_MASTER_QUERY_SS_OutLow     = ssReg;
  assign SPI_MASTER_QUERY_RXDATA_OutBus = rxDataReg;
  assign SPI_MASTER_QUERY_RXVALID_Out   = rxValidReg;
  assign SPI_MASTER_QUERY_BUSY_Out      = busyReg;
  assign SPI_MASTER_QUERY_DONE_Out      = doneReg;

endmodule

// File: tb/tb_spi_master_query.sv
// Self-checking bench for spi_master_query with a behavioural mode-0 slave
// and a transaction-level reference model.
`timescale 1ns/1ps
module tb_spi_master_query;

  localparam int DW     = 8;
  localparam int CLKDIV = 2;
  localparam int MAXB   = 16;
  localparam int CNTW   = 5;
  localparam int SSSET  = 4;
  localparam int GAPC   = 8;
  localparam logic [7:0] CMD_FILLER = 8'hC3;  // slave byte during the command

  logic          clk = 1'b0;
  logic          rstIn;
  logic          startIn;
  logic [DW-1:0] cmdIn;
  logic [4:0]    nbIn;
  logic          miso;
  logic          sck, mosi, ss, rxValid, busy, done;
  logic [DW-1:0] rxData;
`ifdef SPI_MASTER_QUERY_ABORT_EN
  logic          abortIn;
  logic          aborted;
`endif

  always #10 clk = ~clk;

  spi_master_query #(
    .DATAWIDTH_BUS (DW),
    .CLK_DIV       (CLKDIV),
    .MAX_BYTES     (MAXB),
    .CNT_WIDTH     (CNTW),
    .SS_SETUP      (SSSET),
    .BYTE_GAP      (GAPC),
    .TX_FILL       (8'h00)
  ) dut (
    .SPI_MASTER_QUERY_CLOCK_50      (clk),
    .SPI_MASTER_QUERY_RESET_InHigh  (rstIn),
    .SPI_MASTER_QUERY_START_In      (startIn),
    .SPI_MASTER_QUERY_CMD_InBus     (cmdIn),
    .SPI_MASTER_QUERY_NBYTES_InBus  (nbIn),
    .SPI_MASTER_QUERY_MISO_In       (miso),
`ifdef SPI_MASTER_QUERY_ABORT_EN
    .SPI_MASTER_QUERY_ABORT_In      (abortIn),
    .SPI_MASTER_QUERY_ABORTED_Out   (aborted),
`endif
    .SPI_MASTER_QUERY_SCK_Out       (sck),
    .SPI_MASTER_QUERY_MOSI_Out      (mosi),
    .SPI_MASTER_QUERY_SS_OutLow     (ss),
    .SPI_MASTER_QUERY_RXDATA_OutBus (rxData),
    .SPI_MASTER_QUERY_RXVALID_Out   (rxValid),
    .SPI_MASTER_QUERY_BUSY_Out      (busy),
    .SPI_MASTER_QUERY_DONE_Out      (done)
  );

  int tests = 0;
  int fails = 0;

  // Observed per-transaction quantities
  logic [15:0][7:0] curResp;
  logic [7:0] mosiQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] mosiAcc = '0;
  int mosiBits = 0, ssLowCnt = 0, sckRises = 0, doneCnt = 0, doneBad = 0;
  int abortedCnt = 0, abortedAlone = 0;
  int slvBit = 0, slvIdx = 0;
  logic sckPrev = 1'b0;
  logic [7:0] slvByte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: transaction-level quantities from the byte count
  function automatic int refCount(input int nb);
    return (nb > MAXB) ? MAXB : nb;
  endfunction
  function automatic int refSsLow(input int n);
    return 2 * SSSET + (n + 1) * 16 * CLKDIV + n * GAPC;
  endfunction
  function automatic int refRises(input int n);
    return 8 * (n + 1);
  endfunction

  // Bus monitor plus behavioural mode-0 slave, evaluated away from the active edge
  always @(negedge clk) begin
    if (!ss) ssLowCnt++;
    if (sck && !sckPrev) begin
      sckRises++;
      mosiAcc = {mosiAcc[6:0], mosi};
      mosiBits++;
      if (mosiBits == 8) begin
        mosiQ.push_back(mosiAcc);
        mosiBits = 0;
      end
    end
    if (rxValid) rxQ.push_back(rxData);
    if (done) begin
      doneCnt++;
      if (!ss || !busy) doneBad++;
    end
`ifdef SPI_MASTER_QUERY_ABORT_EN
    if (aborted) begin
      abortedCnt++;
      if (!done) abortedAlone++;
    end
`endif
    if (ss) begin
      slvBit = 0;
      slvIdx = 0;
      mosiBits = 0;
    end else if (!sck && sckPrev) begin
      if (slvBit == 7) begin
        slvBit = 0;
        if (slvIdx < 16) slvIdx++;
      end else begin
        slvBit++;
      end
    end
    slvByte = (slvIdx == 0) ? CMD_FILLER : curResp[slvIdx-1];
    miso = slvByte[7-slvBit];
    sckPrev = sck;
  end

  task automatic clearStats();
    mosiQ.delete();
    rxQ.delete();
    ssLowCnt = 0; sckRises = 0; doneCnt = 0; doneBad = 0;
    abortedCnt = 0; abortedAlone = 0;
  endtask

  // One transaction, with optional second START and ABORT at loop cycle offsets
  task automatic runTxn(input logic [7:0] cmd, input int nb, input int restartAt,
                        input int abortAt, output bit timedOut);
    clearStats();
    @(negedge clk);
    startIn = 1'b1; cmdIn = cmd; nbIn = nb[4:0];
    @(negedge clk);
    startIn = 1'b0;
    timedOut = 1'b1;
`ifndef SPI_MASTER_QUERY_ABORT_EN
    if (abortAt >= 0) $display("[TB] abort stimulus skipped (feature not built)");
`endif
    for (int i = 0; i < 3000; i++) begin
      if (i == restartAt) begin
        startIn = 1'b1; cmdIn = 8'h22; nbIn = 5'd3;
      end else if (restartAt >= 0 && i == restartAt + 1) begin
        startIn = 1'b0; cmdIn = cmd;
      end
`ifdef SPI_MASTER_QUERY_ABORT_EN
      abortIn = (i == abortAt);
`endif
      if (!busy) begin
        timedOut = 1'b0;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkTxn(input string tag, input logic [7:0] cmd, input int n,
                          input int expSsLow, input int expRises, input bit timedOut);
    check({tag, ".timeout"}, 32'(timedOut), 0);
    check({tag, ".rxcount"}, rxQ.size(), n);
    for (int i = 0; i < n && i < rxQ.size(); i++)
      check($sformatf("%s.rx%0d", tag, i), 32'(rxQ[i]), 32'(curResp[i]));
    check({tag, ".mosicount"}, mosiQ.size(), n + 1);
    if (mosiQ.size() > 0) check({tag, ".mosicmd"}, 32'(mosiQ[0]), 32'(cmd));
    for (int i = 1; i < mosiQ.size() && i <= n; i++)
      check($sformatf("%s.mosifill%0d", tag, i), 32'(mosiQ[i]), 32'h00);
    check({tag, ".sslow"}, ssLowCnt, expSsLow);
    check({tag, ".sckrises"}, sckRises, expRises);
    check({tag, ".donecount"}, doneCnt, 1);
    check({tag, ".donephase"}, doneBad, 0);
    $display("[TB] txn %s cmd=%02h n=%0d rx=%0d mosiBytes=%0d ssLow=%0d rises=%0d done=%0d",
             tag, cmd, n, rxQ.size(), mosiQ.size(), ssLowCnt, sckRises, doneCnt);
  endtask

  typedef struct {
    logic [7:0]       cmd;
    int               nb;
    logic [15:0][7:0] resp;
    int               expN;
    int               expSsLow;
    int               expRises;
  } vecT;

  vecT tbl [5];

  initial begin
    bit to;
    rstIn = 1'b1; startIn = 1'b0; cmdIn = '0; nbIn = '0; curResp = '0;
`ifdef SPI_MASTER_QUERY_ABORT_EN
    abortIn = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rstIn = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset.ss", 32'(ss), 1);
    check("reset.sck", 32'(sck), 0);
    check("reset.mosi", 32'(mosi), 0);
    check("reset.rxdata", 32'(rxData), 0);
    check("reset.rxvalid", 32'(rxValid), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.done", 32'(done), 0);

    // Directed vectors with hand-derived expectations
    for (int v = 0; v < 5; v++) tbl[v].resp = '0;
    tbl[0].cmd = 8'h11; tbl[0].nb = 2;  tbl[0].expN = 2;  tbl[0].expSsLow = 120; tbl[0].expRises = 24;
    tbl[0].resp[0] = 8'hA5; tbl[0].resp[1] = 8'h3C;
    tbl[1].cmd = 8'hF0; tbl[1].nb = 0;  tbl[1].expN = 0;  tbl[1].expSsLow = 40;  tbl[1].expRises = 8;
    tbl[2].cmd = 8'h5A; tbl[2].nb = 1;  tbl[2].expN = 1;  tbl[2].expSsLow = 80;  tbl[2].expRises = 16;
    tbl[2].resp[0] = 8'h81;
    tbl[3].cmd = 8'hC7; tbl[3].nb = 3;  tbl[3].expN = 3;  tbl[3].expSsLow = 160; tbl[3].expRises = 32;
    tbl[3].resp[0] = 8'h00; tbl[3].resp[1] = 8'hFF; tbl[3].resp[2] = 8'h69;
    tbl[4].cmd = 8'h3E; tbl[4].nb = 31; tbl[4].expN = 16; tbl[4].expSsLow = 680; tbl[4].expRises = 136;
    for (int k = 0; k < 16; k++) tbl[4].resp[k] = 8'(8'h40 + k);

    for (int v = 0; v < 5; v++) begin
      curResp = tbl[v].resp;
      runTxn(tbl[v].cmd, tbl[v].nb, -1, -1, to);
      checkTxn($sformatf("vec%0d", v), tbl[v].cmd, tbl[v].expN, tbl[v].expSsLow, tbl[v].expRises, to);
    end

    // START while busy is ignored
    curResp = '0; curResp[0] = 8'h5C;
    runTxn(8'h11, 1, 10, -1, to);
    checkTxn("restart", 8'h11, 1, refSsLow(1), refRises(1), to);
    begin
      int seen22 = 0;
      foreach (mosiQ[i]) if (mosiQ[i] == 8'h22) seen22++;
      check("restart.no22", seen22, 0);
    end

    // Reset mid-SHIFT, then a normal transaction
    curResp = '0; curResp[0] = 8'hA5; curResp[1] = 8'h3C;
    clearStats();
    @(negedge clk);
    startIn = 1'b1; cmdIn = 8'h11; nbIn = 5'd2;
    @(negedge clk);
    startIn = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst.busybefore", 32'(busy), 1);
    rstIn = 1'b1;
    @(negedge clk);
    check("midrst.ss", 32'(ss), 1);
    check("midrst.sck", 32'(sck), 0);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.mosi", 32'(mosi), 0);
    rstIn = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst.nodone", doneCnt, 0);
    $display("[TB] txn midrst cmd=11 reset after 20 cycles done=%0d", doneCnt);
    runTxn(8'h11, 2, -1, -1, to);
    checkTxn("afterrst", 8'h11, 2, 120, 24, to);

`ifdef SPI_MASTER_QUERY_ABORT_EN
    // Abort during the first response byte: that byte completes, then DONE+ABORTED
    curResp = '0; curResp[0] = 8'hE1; curResp[1] = 8'h22; curResp[2] = 8'h33; curResp[3] = 8'h44;
    runTxn(8'h11, 4, -1, 55, to);
    checkTxn("abort", 8'h11, 1, 80, 16, to);
    check("abort.abortedcount", abortedCnt, 1);
    check("abort.abortedalone", abortedAlone, 0);
`endif

    // Randomized transactions against the reference model
    for (int r = 0; r < 6; r++) begin
      logic [7:0] c;
      int nb, n;
      c = 8'($urandom);
      nb = $urandom_range(0, 31);
      n = refCount(nb);
      for (int k = 0; k < 16; k++) curResp[k] = 8'($urandom);
      runTxn(c, nb, -1, -1, to);
      checkTxn($sformatf("rand%0d", r), c, n, refSsLow(n), refRises(n), to);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
